// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker.
//   - func_sel codes for the supported gate functions (6 and 7 are reserved)
//   - FSM state encoding for the top-level sequencer
//   - helper that flags reserved function codes
package gate_chk_pkg;

    localparam logic [2:0] FN_AND  = 3'd0;
    localparam logic [2:0] FN_OR   = 3'd1;
    localparam logic [2:0] FN_NAND = 3'd2;
    localparam logic [2:0] FN_NOR  = 3'd3;
    localparam logic [2:0] FN_XOR  = 3'd4;
    localparam logic [2:0] FN_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic fn_reserved(input logic [2:0] fn);
        return (fn > FN_XNOR);
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference model of the gate under test: reduces all N_IN
// bits of the vector with the operator selected by func.
// Ports:
//   func     in  3     gate function code (gate_chk_pkg FN_*)
//   vec      in  N_IN  input vector (bit0 = a, bit1 = b, ...)
//   exp_bit  out 1     expected gate output (0 for reserved codes)
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      func,
    input  logic [N_IN-1:0] vec,
    output logic            exp_bit
);

    always_comb begin
        exp_bit = 1'b0;
        case (func)
            FN_AND:  exp_bit = &vec;
            FN_OR:   exp_bit = |vec;
            FN_NAND: exp_bit = ~&vec;
            FN_NOR:  exp_bit = ~|vec;
            FN_XOR:  exp_bit = ^vec;
            FN_XNOR: exp_bit = ~^vec;
            default: exp_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_response_checker.sv
// On-chip self-test partner for a basic logic gate. Sweeps every input
// vector, compares the gate output (after LAT cycles) with a reference model
// and reports a saturating error count, pass/fail and the first failing vector.
// Optional feature macro: GATE_CHK_FAIL_LOG_EN (first-failure capture);
// when undefined fail_vec and fail_valid are tied to 0.
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      begin sweep, honoured only in IDLE
//   func_sel    in   3      gate function (0 AND .. 5 XNOR, 6-7 reserved)
//   stim        out  N_IN   vector driven to the gate inputs
//   dut_out     in   1      gate output
//   busy        out  1      sweep in progress
//   done        out  1      one-cycle pulse at sweep end
//   pass        out  1      no mismatches in last sweep, held until next start
//   err_cnt     out  ERR_W  saturating mismatch count
//   fail_vec    out  N_IN   first mismatching vector
//   fail_valid  out  1      fail_vec holds a capture
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int LAT   = 0,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        func_sel,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [N_IN-1:0]   fail_vec,
    output logic              fail_valid
);

    localparam logic [N_IN-1:0]  STIM_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [2:0]       DRN_LAST  = (LAT == 0) ? 3'd0 : 3'(LAT - 1);

    state_t           state;
    logic [2:0]       func_q;
    logic [2:0]       drn_cnt;
    logic             exp_p0;
    logic             vld_p0;
    logic             chk_vld;
    logic             chk_exp;
    logic             mism;
    logic [ERR_W-1:0] err_nxt;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .func    (func_q),
        .vec     (stim),
        .exp_bit (exp_p0)
    );

    assign vld_p0 = (state == ST_RUN);

    // ---- stage p0 -> compare: expected bit and its valid tag delayed by LAT
    if (LAT == 0) begin : g_nodly
        assign chk_vld = vld_p0;
        assign chk_exp = exp_p0;
    end else begin : g_dly
        logic [LAT-1:0] vld_p;
        logic [LAT-1:0] exp_p;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= '0;
                exp_p <= '0;
            end else begin
                vld_p <= (vld_p << 1) | LAT'(vld_p0);
                exp_p <= (exp_p << 1) | LAT'(exp_p0);
            end
        end
        assign chk_vld = vld_p[LAT-1];
        assign chk_exp = exp_p[LAT-1];
    end

    // Case-inequality so an X/Z gate output is counted as a mismatch.
    assign mism    = (dut_out !== chk_exp);
    assign err_nxt = (chk_vld && mism && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;

    // ---- sequencer: IDLE -> RUN -> DRAIN -> DONE -> IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            func_q  <= '0;
            stim    <= '0;
            drn_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
        end else begin
            done    <= 1'b0;
            err_cnt <= err_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        func_q  <= func_sel;
                        stim    <= '0;
                        drn_cnt <= '0;
                        err_cnt <= '0;
                        pass    <= 1'b0;
                        if (fn_reserved(func_sel)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stim == STIM_LAST) begin
                        if (LAT == 0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (err_nxt == '0);
                        end else begin
                            state   <= ST_DRAIN;
                            drn_cnt <= '0;
                        end
                    end else begin
                        stim <= stim + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The last tag leaves the delay line on the final drain cycle.
                    if (drn_cnt == DRN_LAST) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_nxt == '0);
                    end else begin
                        drn_cnt <= drn_cnt + 3'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GATE_CHK_FAIL_LOG_EN
    logic [N_IN-1:0] chk_vec;

    // The stimulus vector rides alongside the expected bit so a capture
    // records the vector that actually produced the mismatch.
    if (LAT == 0) begin : g_vec_nodly
        assign chk_vec = stim;
    end else begin : g_vec_dly
        logic [N_IN-1:0] vec_p [LAT];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < LAT; i++) vec_p[i] <= '0;
            end else begin
                vec_p[0] <= stim;
                for (int i = 1; i < LAT; i++) vec_p[i] <= vec_p[i-1];
            end
        end
        assign chk_vec = vec_p[LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else if (chk_vld && mism && !fail_valid) begin
            fail_vec   <= chk_vec;
            fail_valid <= 1'b1;
        end
    end
`else
    assign fail_vec   = '0;
    assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker. Three checker instances cover the
// combinational/registered DUT cases and a narrow saturating counter; each
// sees a behavioural gate built from a truth table (tt) the bench fills in.
`timescale 1ns/1ps
module tb_gate_response_checker;

    localparam int NIN  [3] = '{2, 2, 3};
    localparam int LATK [3] = '{0, 3, 0};
    localparam int ERRW [3] = '{8, 8, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [2:0] func_sel;
    int         cur;
    logic       tt [256];

    logic       s0, s1, s2;
    logic [1:0] stim0, stim1;
    logic [2:0] stim2;
    logic       dut0, dut1, dut2;
    logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [7:0] err0, err1;
    logic [1:0] err2;
    logic [1:0] fv0, fv1;
    logic [2:0] fv2;
    logic       fvld0, fvld1, fvld2;
    logic [2:0] d1p;

    int errors = 0;
    int checks = 0;

    assign s0 = start && (cur == 0);
    assign s1 = start && (cur == 1);
    assign s2 = start && (cur == 2);

    // Behavioural gates: combinational for instances 0/2, three registers deep for 1.
    assign dut0 = tt[int'(stim0)];
    assign dut2 = tt[int'(stim2)];
    always @(posedge clk) d1p <= {d1p[1:0], tt[int'(stim1)]};
    assign dut1 = d1p[2];

    gate_response_checker #(.N_IN(2), .LAT(0), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(s0), .func_sel(func_sel), .stim(stim0),
        .dut_out(dut0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_vec(fv0), .fail_valid(fvld0));
    gate_response_checker #(.N_IN(2), .LAT(3), .ERR_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .func_sel(func_sel), .stim(stim1),
        .dut_out(dut1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_vec(fv1), .fail_valid(fvld1));
    gate_response_checker #(.N_IN(3), .LAT(0), .ERR_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .func_sel(func_sel), .stim(stim2),
        .dut_out(dut2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .fail_vec(fv2), .fail_valid(fvld2));

    logic [7:0] v_stim, v_err, v_fv;
    logic       v_busy, v_done, v_pass, v_fvld;

    always_comb begin
        v_stim = '0; v_err = '0; v_fv = '0;
        v_busy = 1'b0; v_done = 1'b0; v_pass = 1'b0; v_fvld = 1'b0;
        case (cur)
            0: begin v_stim = 8'(stim0); v_err = err0; v_fv = 8'(fv0); v_busy = busy0;
                     v_done = done0; v_pass = pass0; v_fvld = fvld0; end
            1: begin v_stim = 8'(stim1); v_err = err1; v_fv = 8'(fv1); v_busy = busy1;
                     v_done = done1; v_pass = pass1; v_fvld = fvld1; end
            default: begin v_stim = 8'(stim2); v_err = 8'(err2); v_fv = 8'(fv2); v_busy = busy2;
                     v_done = done2; v_pass = pass2; v_fvld = fvld2; end
        endcase
    end

    // Gate truth from the number of ones among the n inputs.
    function automatic logic gate_ref(input int fn, input int v, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += (v >> i) & 1;
        case (fn)
            0: return ones == n;
            1: return ones > 0;
            2: return ones != n;
            3: return ones == 0;
            4: return (ones % 2) == 1;
            5: return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic fill_tt(input int fn, input int n, input bit invert);
        for (int v = 0; v < 256; v++) tt[v] = invert ? !gate_ref(fn, v, n) : gate_ref(fn, v, n);
    endtask

    // inj: 0 none, 1 start pulse while busy, 2 start pulse while in DONE.
    task automatic run_sweep(input int k, input int fn, input int inj, input string tag);
        int n, nv, emax, nerr, first, dexp, m, exp_err, bad_m, want;
        bit res, exp_pass, stim_ok, busy_ok;
        logic [7:0] bad_val;
        logic [7:0] exp_fv;
        logic       exp_fvld;
        n = NIN[k]; nv = 1 << n; emax = (1 << ERRW[k]) - 1;
        res = (fn > 5);
        nerr = 0; first = -1;
        if (!res) begin
            for (int v = 0; v < nv; v++)
                if (tt[v] !== gate_ref(fn, v, n)) begin
                    nerr++;
                    if (first < 0) first = v;
                end
        end
        exp_err  = (nerr > emax) ? emax : nerr;
        exp_pass = !res && (nerr == 0);
        dexp     = res ? 0 : nv + LATK[k];
`ifdef GATE_CHK_FAIL_LOG_EN
        exp_fvld = (first >= 0);
        exp_fv   = (first >= 0) ? 8'(first) : 8'd0;
`else
        exp_fvld = 1'b0;
        exp_fv   = 8'd0;
`endif
        @(negedge clk);
        cur = k; func_sel = 3'(fn); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m = 0; stim_ok = 1; busy_ok = 1; bad_m = 0; bad_val = '0;
        while (!v_done && m < 1000) begin
            want = (m < nv) ? m : nv - 1;
            if (stim_ok && v_stim !== 8'(want)) begin stim_ok = 0; bad_m = m; bad_val = v_stim; end
            if (v_busy !== 1'b1) busy_ok = 0;
            start = (inj == 1 && m == 2);
            @(negedge clk);
            m++;
        end
        start = 1'b0;
        checks++;
        if (!v_done || m != dexp) begin
            errors++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, m, dexp);
        end
        if (!res) begin
            checks++;
            if (!stim_ok) begin
                errors++; $display("FAIL %s stim_seq: step %0d got %0d expected %0d", tag, bad_m, bad_val,
                                   (bad_m < nv) ? bad_m : nv - 1);
            end
            checks++;
            if (!busy_ok) begin errors++; $display("FAIL %s busy_during: got low expected high", tag); end
        end
        checks++;
        if (v_err !== 8'(exp_err)) begin
            errors++; $display("FAIL %s err_cnt: got %0d expected %0d", tag, v_err, exp_err);
        end
        checks++;
        if (v_pass !== exp_pass) begin
            errors++; $display("FAIL %s pass: got %0b expected %0b", tag, v_pass, exp_pass);
        end
        checks++;
        if (v_busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %0b expected 0", tag, v_busy); end
        checks++;
        if (v_fvld !== exp_fvld || v_fv !== exp_fv) begin
            errors++; $display("FAIL %s fail_log: got %0b/%0d expected %0b/%0d", tag, v_fvld, v_fv, exp_fvld, exp_fv);
        end
        start = (inj == 2);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (v_done !== 1'b0 || v_busy !== 1'b0 || v_pass !== exp_pass) begin
            errors++; $display("FAIL %s after_done: got done=%0b busy=%0b pass=%0b expected 0 0 %0b",
                               tag, v_done, v_busy, v_pass, exp_pass);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            cur = k;
            #1;
            checks++;
            if ({v_stim, v_err, v_fv, v_busy, v_done, v_pass, v_fvld} !== '0) begin
                errors++;
                $display("FAIL %s inst%0d: got stim=%0d err=%0d fv=%0d busy=%0b done=%0b pass=%0b fvld=%0b expected all 0",
                         tag, k, v_stim, v_err, v_fv, v_busy, v_done, v_pass, v_fvld);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; func_sel = 3'd0; cur = 0;
        fill_tt(0, 3, 0);
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("post_reset");
    endtask

    task automatic test_nand_correct();
        fill_tt(2, 2, 0);
        run_sweep(0, 2, 0, "nand_ok");
    endtask

    task automatic test_stuck_at_1();
        for (int v = 0; v < 256; v++) tt[v] = 1'b1;
        run_sweep(0, 2, 0, "stuck1");
    endtask

    task automatic test_latency();
        fill_tt(4, 2, 0);
        run_sweep(1, 4, 0, "lat3_xor");
        run_sweep(1, 0, 0, "lat3_and_on_xor");
    endtask

    task automatic test_saturate();
        fill_tt(4, 3, 1);
        run_sweep(2, 4, 0, "sat_inv");
    endtask

    task automatic test_mid_reset();
        int guard;
        fill_tt(2, 2, 0);
        @(negedge clk);
        cur = 0; func_sel = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (v_stim !== 8'd2 && guard < 10) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 10) begin errors++; $display("FAIL mid_reset_reach: got stim=%0d expected 2", v_stim); end
        #2 rst_n = 1'b0;
        check_idle_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 2, 0, "after_reset");
    endtask

    task automatic test_reserved_and_ignore();
        run_sweep(0, 7, 0, "reserved7");
        run_sweep(2, 6, 0, "reserved6");
        fill_tt(4, 2, 0);
        run_sweep(1, 4, 1, "start_busy");
        fill_tt(1, 2, 0);
        run_sweep(0, 1, 2, "start_done");
    endtask

    task automatic test_random();
        int k, fn, mode, n;
        for (int it = 0; it < 16; it++) begin
            k  = $urandom_range(0, 2);
            fn = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            n  = NIN[k];
            mode = $urandom_range(0, 3);
            fill_tt((fn > 5) ? 0 : fn, n, 0);
            if (mode == 1) begin
                for (int v = 0; v < 256; v++) tt[v] = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                int f;
                f = $urandom_range(0, (1 << n) - 1);
                tt[f] = !tt[f];
            end else if (mode == 3) begin
                tt[$urandom_range(0, (1 << n) - 1)] = 1'bx;
            end
            run_sweep(k, fn, $urandom_range(0, 2), $sformatf("rand%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_nand_correct();
        test_stuck_at_1();
        test_latency();
        test_saturate();
        test_mid_reset();
        test_reserved_and_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
